// File: rtl/bp_resolve_unit_pkg.sv
// bp_resolve_unit_pkg: prediction record, FSM states and opcodes shared with the IF-side predictor
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
package bp_resolve_unit_pkg;
    localparam int INST_AW = `INST_ADDR_WIDTH;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bp_state_e;
    typedef struct packed {
        logic [INST_AW-1:0] pc;
        logic               is_branch;
        logic               taken;
        logic [INST_AW-1:0] target;
    } bp_pred_rec_t;
    function automatic logic [INST_AW-1:0] seq_pc(input logic [INST_AW-1:0] pc);
        return pc + INST_AW'(4);
    endfunction
endpackage

// File: rtl/bp_resolve_unit_fifo.sv
// bp_pred_fifo: power-of-two circular buffer with push/pop/clear; caller never pushes full or pops empty
module bp_pred_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop_i);
            tail_q  <= tail_q + PW'(push_i);
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= wdata_i;
    end
    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/bp_resolve_unit.sv
// bp_resolve_unit: in-order branch resolution, flush/redirect and BHT update; BP_RESOLVE_STATS_EN adds counters
module bp_resolve_unit
    import bp_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = INST_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pred_valid_i,
    output logic                   pred_ready_o,
    input  logic [AW-1:0]          pred_pc_i,
    input  logic                   pred_is_branch_i,
    input  logic                   pred_taken_i,
    input  logic [AW-1:0]          pred_target_i,
    input  logic                   res_valid_i,
    input  logic [AW-1:0]          res_pc_i,
    input  logic                   res_taken_i,
    input  logic [AW-1:0]          res_target_i,
    output logic                   flush_o,
    output logic [AW-1:0]          redirect_pc_o,
    output logic                   update_valid_o,
    output logic [AW-1:0]          update_pc_o,
    output logic                   real_taken_o,
    output logic                   err_o,
    output logic [$clog2(DEPTH):0] occupancy_o
`ifdef BP_RESOLVE_STATS_EN
    ,
    output logic [31:0]            stat_resolved_o,
    output logic [31:0]            stat_mispred_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    bp_state_e    state_q, state_d;
    bp_pred_rec_t head, wrec;
    logic [CW-1:0] count;
    logic          resolve, empty, seq_err, mispred, flush_d, push, pop, upd_d;
    logic [AW-1:0] correct_pc;
    logic          flush_q, upd_q, real_taken_q, err_q;
    logic [AW-1:0] redirect_q, upd_pc_q;

    assign wrec = '{pc: pred_pc_i, is_branch: pred_is_branch_i, taken: pred_taken_i, target: pred_target_i};
    assign empty        = count == '0;
    assign pred_ready_o = (state_q == ST_RUN) && (count != CW'(DEPTH));
    assign resolve      = (state_q == ST_RUN) && res_valid_i;
    assign seq_err      = resolve && (empty || res_pc_i != head.pc);
    assign mispred      = resolve && !empty &&
                          (head.taken != res_taken_i || (res_taken_i && head.target != res_target_i));
    assign flush_d      = seq_err || mispred;
    // a push landing in the same cycle as a flush is wrong-path and dropped by clear
    assign push         = pred_valid_i && pred_ready_o;
    assign pop          = resolve && !empty;
    assign upd_d        = resolve && !seq_err && head.is_branch;
    assign correct_pc   = res_taken_i ? res_target_i : seq_pc(res_pc_i);

    bp_pred_fifo #(.DEPTH(DEPTH), .W($bits(bp_pred_rec_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_d),
        .wdata_i (wrec),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        state_d = ST_RUN;
        if (state_q == ST_RUN && flush_d) state_d = ST_FLUSH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            upd_q        <= 1'b0;
            upd_pc_q     <= '0;
            real_taken_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            redirect_q   <= flush_d ? correct_pc : '0;
            upd_q        <= upd_d;
            upd_pc_q     <= upd_d ? head.pc : '0;
            real_taken_q <= upd_d && res_taken_i;
            err_q        <= err_q || seq_err;
        end
    end

    assign flush_o        = flush_q;
    assign redirect_pc_o  = redirect_q;
    assign update_valid_o = upd_q;
    assign update_pc_o    = upd_pc_q;
    assign real_taken_o   = real_taken_q;
    assign err_o          = err_q;
    assign occupancy_o    = count;

`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] res_cnt_q, mis_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (resolve && res_cnt_q != '1) res_cnt_q <= res_cnt_q + 32'd1;
            if (flush_d && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end
    assign stat_resolved_o = res_cnt_q;
    assign stat_mispred_o  = mis_cnt_q;
`endif
endmodule

// File: tb/tb_bp_resolve_unit.sv
// tb_bp_resolve_unit: queue-based reference model with per-cycle compare plus directed literal checks
module tb_bp_resolve_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          pred_valid_i, pred_is_branch_i, pred_taken_i, res_valid_i, res_taken_i;
    logic [AW-1:0] pred_pc_i, pred_target_i, res_pc_i, res_target_i;
    logic          pred_ready_o, flush_o, update_valid_o, real_taken_o, err_o;
    logic [AW-1:0] redirect_pc_o, update_pc_o;
    logic [CW-1:0] occupancy_o;
`ifdef BP_RESOLVE_STATS_EN
    logic [31:0]   stat_resolved_o, stat_mispred_o;
`endif

    bp_resolve_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid_i     (pred_valid_i),
        .pred_ready_o     (pred_ready_o),
        .pred_pc_i        (pred_pc_i),
        .pred_is_branch_i (pred_is_branch_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .res_valid_i      (res_valid_i),
        .res_pc_i         (res_pc_i),
        .res_taken_i      (res_taken_i),
        .res_target_i     (res_target_i),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o),
        .update_valid_o   (update_valid_o),
        .update_pc_o      (update_pc_o),
        .real_taken_o     (real_taken_o),
        .err_o            (err_o),
        .occupancy_o      (occupancy_o)
`ifdef BP_RESOLVE_STATS_EN
        ,
        .stat_resolved_o  (stat_resolved_o),
        .stat_mispred_o   (stat_mispred_o)
`endif
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic          br;
        logic          tk;
        logic [AW-1:0] tg;
    } rec_t;

    rec_t          mq[$];
    logic          m_in_flush, m_err, e_flush, e_uv, e_rt;
    logic [AW-1:0] e_redir, e_upc;
    int unsigned   m_res, m_mis;
    int            compared = 0;
    int            mismatched = 0;
    logic          mon = 1'b0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_flush = 1'b0;
        m_err      = 1'b0;
        e_flush    = 1'b0;
        e_uv       = 1'b0;
        e_rt       = 1'b0;
        e_redir    = '0;
        e_upc      = '0;
        m_res      = 0;
        m_mis      = 0;
    endtask

    // applies one clock of the architectural rules to the model, using the inputs the DUT just sampled
    task automatic model_step();
        logic fl, uv, rt, rdy;
        logic [AW-1:0] rd, up;
        rec_t r;
        fl = 0; uv = 0; rt = 0; rd = '0; up = '0;
        rdy = !m_in_flush && mq.size() < DEPTH;
        if (!m_in_flush && res_valid_i) begin
            m_res++;
            if (mq.size() == 0 || mq[0].pc != res_pc_i) begin
                fl = 1;
                m_err = 1;
            end else begin
                fl = (mq[0].tk != res_taken_i) || (res_taken_i && mq[0].tg != res_target_i);
                uv = mq[0].br;
                up = mq[0].pc;
                rt = res_taken_i;
                void'(mq.pop_front());
            end
            if (fl) begin
                m_mis++;
                rd = res_taken_i ? res_target_i : res_pc_i + 32'd4;
            end
        end
        if (fl) mq.delete();
        else if (pred_valid_i && rdy) begin
            r.pc = pred_pc_i; r.br = pred_is_branch_i; r.tk = pred_taken_i; r.tg = pred_target_i;
            mq.push_back(r);
        end
        m_in_flush = fl;
        e_flush = fl; e_redir = rd; e_uv = uv; e_upc = up; e_rt = rt;
    endtask

    always @(negedge clk) begin
        if (mon) begin
            chk("flush", flush_o, e_flush);
            if (e_flush) chk("redirect", redirect_pc_o, e_redir);
            chk("upd_valid", update_valid_o, e_uv);
            if (e_uv) begin
                chk("upd_pc", update_pc_o, e_upc);
                chk("real_taken", real_taken_o, e_rt);
            end
            chk("err", err_o, m_err);
            chk("ready", pred_ready_o, !m_in_flush && mq.size() < DEPTH);
            chk("occupancy", occupancy_o, mq.size());
`ifdef BP_RESOLVE_STATS_EN
            chk("stat_resolved", stat_resolved_o, m_res);
            chk("stat_mispred", stat_mispred_o, m_mis);
`endif
        end
    end

    task automatic drive(input logic pv, input logic [AW-1:0] ppc, input logic pbr, input logic ptk,
                         input logic [AW-1:0] ptg, input logic rv, input logic [AW-1:0] rpc,
                         input logic rtk, input logic [AW-1:0] rtg);
        pred_valid_i = pv; pred_pc_i = ppc; pred_is_branch_i = pbr; pred_taken_i = ptk; pred_target_i = ptg;
        res_valid_i = rv; res_pc_i = rpc; res_taken_i = rtk; res_target_i = rtg;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic br, input logic tk, input logic [AW-1:0] tg);
        drive(1, pc, br, tk, tg, 0, '0, 0, '0);
    endtask

    task automatic resolve(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg);
        drive(0, '0, 0, 0, '0, 1, pc, tk, tg);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic rnd(input int n);
        logic pv, pbr, ptk, rv, rtk;
        logic [AW-1:0] ppc, ptg, rpc, rtg;
        for (int i = 0; i < n; i++) begin
            pv = 1'($urandom % 2); pbr = 1'($urandom % 2); ptk = 1'($urandom % 2);
            ppc = AW'($urandom_range(0, 1023)) << 2;
            ptg = AW'($urandom_range(0, 1023)) << 2;
            if (mq.size() > 0 && $urandom % 16 != 0) begin
                rv  = 1'($urandom % 2);
                rpc = mq[0].pc;
                rtk = ($urandom % 8 == 0) ? !mq[0].tk : mq[0].tk;
                rtg = ($urandom % 8 == 0) ? (mq[0].tg ^ 32'h10) : mq[0].tg;
            end else begin
                rv  = ($urandom % 8 == 0);
                rpc = AW'($urandom_range(0, 1023)) << 2;
                rtk = 1'($urandom % 2);
                rtg = AW'($urandom_range(0, 1023)) << 2;
            end
            drive(pv, ppc, pbr, ptk, ptg, rv, rpc, rtk, rtg);
        end
    endtask

    initial begin
        pred_valid_i = 0; pred_pc_i = '0; pred_is_branch_i = 0; pred_taken_i = 0; pred_target_i = '0;
        res_valid_i = 0; res_pc_i = '0; res_taken_i = 0; res_target_i = '0;
        model_reset();
        #1 rst_n = 1'b0;
        mon = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", pred_ready_o, 1);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_uv", update_valid_o, 0);
        chk("rst_err", err_o, 0);

        push(32'h100, 1, 0, 32'h180);
        resolve(32'h100, 0, '0);
        chk("t1_uv", update_valid_o, 1);
        chk("t1_upc", update_pc_o, 32'h100);
        chk("t1_rt", real_taken_o, 0);
        chk("t1_flush", flush_o, 0);

        push(32'h200, 1, 1, 32'h180);
        push(32'h208, 1, 0, 32'h300);
        resolve(32'h200, 0, '0);
        chk("t2_flush", flush_o, 1);
        chk("t2_redir", redirect_pc_o, 32'h204);
        chk("t2_uv", update_valid_o, 1);
        chk("t2_rt", real_taken_o, 0);
        chk("t2_occ", occupancy_o, 0);
        chk("t2_ready", pred_ready_o, 0);
        idle();
        chk("t2_flush_end", flush_o, 0);
        chk("t2_ready_back", pred_ready_o, 1);

        push(32'h300, 0, 0, '0);
        resolve(32'h300, 1, 32'h400);
        chk("t3_flush", flush_o, 1);
        chk("t3_redir", redirect_pc_o, 32'h400);
        chk("t3_uv", update_valid_o, 0);
        idle();

        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(4 * i), 1, 0, 32'h2000);
        chk("t4_full_ready", pred_ready_o, 0);
        chk("t4_full_occ", occupancy_o, DEPTH);
        drive(1, 32'h5000, 1, 0, '0, 1, 32'h1000, 0, '0);
        chk("t4_occ_after", occupancy_o, DEPTH - 1);
        chk("t4_flush", flush_o, 0);
        for (int i = 0; i < DEPTH && mq.size() > 0; i++) resolve(mq[0].pc, mq[0].tk, mq[0].tg);
        chk("t4_drained", occupancy_o, 0);

        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (mq.size() > 0) drive(1, 32'h3000 + 32'(4 * i), 1'(i % 2), 1'(i % 3 == 0), 32'h3800,
                                     1, mq[0].pc, mq[0].tk, mq[0].tg);
            else push(32'h3000 + 32'(4 * i), 1'(i % 2), 1'(i % 3 == 0), 32'h3800);
        end
        for (int i = 0; i < DEPTH && mq.size() > 0; i++) resolve(mq[0].pc, mq[0].tk, mq[0].tg);
        chk("wrap_err", err_o, 0);
        chk("wrap_occ", occupancy_o, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            push(32'h4000 + 32'(8 * i), 1, 0, 32'h4100);
            if (i == 3 || i == 6 || i == 9) begin
                resolve(32'h4000 + 32'(8 * i), 1, 32'h4100);
                idle();
            end else resolve(32'h4000 + 32'(8 * i), 0, '0);
        end
`ifdef BP_RESOLVE_STATS_EN
        chk("stat10", stat_resolved_o, 10);
        chk("stat3", stat_mispred_o, 3);
`endif

        do_reset();
        resolve(32'h500, 0, '0);
        chk("e_err", err_o, 1);
        chk("e_flush", flush_o, 1);
        chk("e_redir", redirect_pc_o, 32'h504);
        chk("e_uv", update_valid_o, 0);
        idle();
        idle();
        chk("e_sticky", err_o, 1);

        rnd(3000);

        idle();
        idle();
        push(32'h600, 1, 0, '0);
        resolve(32'h600, 1, 32'h700);
        chk("mr_pre_flush", flush_o, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_flush", flush_o, 0);
        chk("mr_ready", pred_ready_o, 1);
        chk("mr_occ", occupancy_o, 0);
        chk("mr_err", err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rnd(500);
        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
